fetch_redirect: RTL and testbench

- Fetch-side partner of the ID-stage branch validity logic.
- Owns the PC register, the synchronous instruction-memory address and the IF/ID pipeline register.
- Produces `valid_out_IFID`. Acts on taken BEQ/JAL/JLR/JRI redirects resolved in ID by squashing wrong-path fetches.
- Holds fetched words across hazard stalls.

---
 rtl/fetch_redirect_if.sv | 24 ++
 rtl/fetch_redirect.sv | 81 ++++++++
 tb/tb_fetch_redirect.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_if.sv
// rtl/fetch_redirect_if.sv - fetch-side bus: ID stall/redirect in, imem address out, IF/ID register out
interface fetch_redirect_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            br_valid;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] instr_in;
    logic [PC_W-1:0] pc_out;
    logic [PC_W-1:0] instr_IFID;
    logic [PC_W-1:0] pc_IFID;
    logic            valid_out_IFID;
    logic            redirect;

    modport master (
        input  stall, br_valid, br_target, instr_in,
        output pc_out, instr_IFID, pc_IFID, valid_out_IFID, redirect
    );

    modport slave (
        output stall, br_valid, br_target, instr_in,
        input  pc_out, instr_IFID, pc_IFID, valid_out_IFID, redirect
    );
endinterface

// File: rtl/fetch_redirect.sv
// rtl/fetch_redirect.sv - PC, synchronous imem addressing and IF/ID register with stall skid and redirect flush
module fetch_redirect #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_redirect_if.master   bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d1;
    logic            d1_valid;
    logic [PC_W-1:0] hold_instr;
    logic            hold_valid;
    logic [PC_W-1:0] instr_q;
    logic [PC_W-1:0] pc_ifid_q;
    logic            valid_q;
    logic            redirect_q;
    logic            accept;

    // Only a valid ID instruction may redirect, which also rules out back-to-back redirects.
    assign accept = (state == RUN) && !bus.stall && bus.br_valid && valid_q;

    assign bus.pc_out         = pc_q;
    assign bus.instr_IFID     = instr_q;
    assign bus.pc_IFID        = pc_ifid_q;
    assign bus.valid_out_IFID = valid_q;
    assign bus.redirect       = redirect_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_d1      <= RESET_PC;
            d1_valid   <= 1'b0;
            instr_q    <= '0;
            pc_ifid_q  <= '0;
            valid_q    <= 1'b0;
            hold_instr <= '0;
            hold_valid <= 1'b0;
            redirect_q <= 1'b0;
            state      <= RUN;
        end else if (state == FLUSH) begin
            // The word arriving now was fetched from the old path; retire it as a bubble.
            instr_q    <= bus.instr_in;
            pc_ifid_q  <= pc_d1;
            valid_q    <= 1'b0;
            pc_d1      <= pc_q;
            d1_valid   <= 1'b1;
            pc_q       <= pc_q + PC_W'(1);
            hold_valid <= 1'b0;
            redirect_q <= 1'b0;
            state      <= RUN;
        end else if (bus.stall) begin
            redirect_q <= 1'b0;
            // Capture only the first returned word; later reads repeat the frozen address.
            if (!hold_valid) begin
                hold_instr <= bus.instr_in;
                hold_valid <= 1'b1;
            end
        end else if (accept) begin
            pc_q       <= bus.br_target;
            valid_q    <= 1'b0;
            d1_valid   <= 1'b0;
            hold_valid <= 1'b0;
            redirect_q <= 1'b1;
            state      <= FLUSH;
        end else begin
            instr_q    <= hold_valid ? hold_instr : bus.instr_in;
            pc_ifid_q  <= pc_d1;
            valid_q    <= d1_valid;
            pc_d1      <= pc_q;
            d1_valid   <= 1'b1;
            pc_q       <= pc_q + PC_W'(1);
            hold_valid <= 1'b0;
            redirect_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_redirect.sv
// tb/tb_fetch_redirect.sv - directed and randomized checks of fetch_redirect against a fetch-stream model
module tb_fetch_redirect;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_redirect_if #(.PC_W(W)) bus ();

    fetch_redirect #(.PC_W(W), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Model: expected fetch address, IF/ID validity/address, and the number of
    // advancing edges still needed before the next correct-path word shows up.
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_pcifid;
    logic        m_redirect;
    logic        m_flush;
    int          m_pending;
    logic [15:0] m_next;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    task automatic step(input logic s, input logic bv, input logic [15:0] bt, input logic rn);
        logic [15:0] prev;
        rst_n         = rn;
        bus.stall     = s;
        bus.br_valid  = bv;
        bus.br_target = bt;
        prev          = bus.pc_out;
        m_redirect    = 1'b0;
        if (!rn) begin
            m_pc = 16'h0000; m_valid = 1'b0; m_flush = 1'b0; m_pending = 2; m_next = 16'h0000;
        end else if (m_flush) begin
            m_flush = 1'b0; m_valid = 1'b0; m_pending = 1; m_pc = m_pc + 16'd1;
        end else if (s) begin
            m_flush = 1'b0;
        end else if (bv && m_valid) begin
            m_valid = 1'b0; m_flush = 1'b1; m_next = bt; m_pc = bt; m_redirect = 1'b1;
        end else begin
            m_pc = m_pc + 16'd1;
            if (m_pending > 0) m_pending--;
            if (m_pending == 0) begin
                m_valid = 1'b1; m_pcifid = m_next; m_next = m_next + 16'd1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.instr_in = memf(prev);
    endtask

    task automatic test_reset();
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out got %h exp 0000", bus.pc_out); end
        checks++; if (bus.valid_out_IFID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_out_IFID); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", bus.redirect); end
        checks++; if (bus.instr_IFID !== 16'h0000 || bus.pc_IFID !== 16'h0000) begin
            errors++; $display("FAIL reset_ifid got %h/%h exp 0000/0000", bus.instr_IFID, bus.pc_IFID); end
        for (int k = 1; k <= 4; k++) begin
            logic [15:0] ek;
            step(0, 0, 16'h0, 1);
            ek = 16'(k);
            checks++; if (bus.pc_out !== ek) begin errors++; $display("FAIL seq_pc_out step %0d got %h exp %h", k, bus.pc_out, ek); end
            checks++; if (bus.valid_out_IFID !== (k >= 2)) begin errors++; $display("FAIL seq_valid step %0d got %b exp %b", k, bus.valid_out_IFID, k >= 2); end
            if (k >= 2) begin
                checks++; if (bus.pc_IFID !== ek - 16'd2 || bus.instr_IFID !== 16'h1000 + ek - 16'd2) begin
                    errors++; $display("FAIL seq_ifid step %0d got %h/%h exp %h/%h", k, bus.pc_IFID, bus.instr_IFID, ek - 16'd2, 16'h1000 + ek - 16'd2); end
            end
        end
    endtask

    task automatic test_redirect();
        step(0, 0, 16'h0, 1);
        checks++; if (bus.pc_IFID !== 16'h0003 || bus.valid_out_IFID !== 1'b1) begin
            errors++; $display("FAIL redir_pre got %h/%b exp 0003/1", bus.pc_IFID, bus.valid_out_IFID); end
        step(0, 1, 16'h0040, 1);
        checks++; if (bus.valid_out_IFID !== 1'b0 || bus.redirect !== 1'b1 || bus.pc_out !== 16'h0040) begin
            errors++; $display("FAIL redir_accept got v%b r%b pc %h exp v0 r1 pc 0040", bus.valid_out_IFID, bus.redirect, bus.pc_out); end
        step(0, 0, 16'h0, 1);
        checks++; if (bus.valid_out_IFID !== 1'b0 || bus.redirect !== 1'b0 || bus.pc_out !== 16'h0041) begin
            errors++; $display("FAIL redir_flush got v%b r%b pc %h exp v0 r0 pc 0041", bus.valid_out_IFID, bus.redirect, bus.pc_out); end
        step(0, 0, 16'h0, 1);
        checks++; if (bus.valid_out_IFID !== 1'b1 || bus.pc_IFID !== 16'h0040 || bus.instr_IFID !== 16'h1040) begin
            errors++; $display("FAIL redir_target got v%b %h/%h exp v1 0040/1040", bus.valid_out_IFID, bus.pc_IFID, bus.instr_IFID); end
        step(0, 0, 16'h0, 1);
        checks++; if (bus.valid_out_IFID !== 1'b1 || bus.pc_IFID !== 16'h0041 || bus.instr_IFID !== 16'h1041) begin
            errors++; $display("FAIL redir_next got v%b %h/%h exp v1 0041/1041", bus.valid_out_IFID, bus.pc_IFID, bus.instr_IFID); end
    endtask

    task automatic test_stall();
        logic [15:0] x;
        logic [15:0] p;
        x = m_pcifid;
        p = m_pc;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 16'h0, 1);
            checks++; if (bus.pc_IFID !== x || bus.valid_out_IFID !== 1'b1 || bus.pc_out !== p) begin
                errors++; $display("FAIL stall_hold cyc %0d got %h/%b pc %h exp %h/1 pc %h", k, bus.pc_IFID, bus.valid_out_IFID, bus.pc_out, x, p); end
        end
        for (int k = 1; k <= 3; k++) begin
            logic [15:0] e;
            step(0, 0, 16'h0, 1);
            e = x + 16'(k);
            checks++; if (bus.pc_IFID !== e || bus.instr_IFID !== memf(e) || bus.valid_out_IFID !== 1'b1) begin
                errors++; $display("FAIL stall_release k %0d got %h/%h/%b exp %h/%h/1", k, bus.pc_IFID, bus.instr_IFID, bus.valid_out_IFID, e, memf(e)); end
        end
    endtask

    task automatic test_stall_branch();
        logic [15:0] p;
        p = m_pc;
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 16'h0200, 1);
            checks++; if (bus.redirect !== 1'b0 || bus.pc_out !== p) begin
                errors++; $display("FAIL stallbr_hold cyc %0d got r%b pc %h exp r0 pc %h", k, bus.redirect, bus.pc_out, p); end
        end
        step(0, 1, 16'h0200, 1);
        checks++; if (bus.redirect !== 1'b1 || bus.pc_out !== 16'h0200) begin
            errors++; $display("FAIL stallbr_accept got r%b pc %h exp r1 pc 0200", bus.redirect, bus.pc_out); end
        step(1, 1, 16'h0300, 1);
        checks++; if (bus.redirect !== 1'b0 || bus.pc_out !== 16'h0201 || bus.valid_out_IFID !== 1'b0) begin
            errors++; $display("FAIL flush_ignore got r%b pc %h v%b exp r0 pc 0201 v0", bus.redirect, bus.pc_out, bus.valid_out_IFID); end
        step(0, 1, 16'h0300, 1);
        checks++; if (bus.redirect !== 1'b0 || bus.pc_out !== 16'h0202 || bus.pc_IFID !== 16'h0200 || bus.valid_out_IFID !== 1'b1) begin
            errors++; $display("FAIL invalid_ignore got r%b pc %h ifid %h v%b exp r0 pc 0202 ifid 0200 v1", bus.redirect, bus.pc_out, bus.pc_IFID, bus.valid_out_IFID); end
    endtask

    task automatic test_wrap();
        step(0, 1, 16'hFFFE, 1);
        step(0, 0, 16'h0, 1);
        checks++; if (bus.pc_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", bus.pc_out); end
        step(0, 0, 16'h0, 1);
        checks++; if (bus.pc_out !== 16'h0000 || bus.pc_IFID !== 16'hFFFE || bus.instr_IFID !== 16'h0FFE) begin
            errors++; $display("FAIL wrap_0000 got pc %h ifid %h/%h exp 0000 fffe/0ffe", bus.pc_out, bus.pc_IFID, bus.instr_IFID); end
        step(0, 0, 16'h0, 1);
        checks++; if (bus.pc_IFID !== 16'hFFFF || bus.pc_out !== 16'h0001) begin
            errors++; $display("FAIL wrap_next got ifid %h pc %h exp ffff 0001", bus.pc_IFID, bus.pc_out); end
    endtask

    task automatic test_reset_mid_flush();
        step(0, 1, 16'h0123, 1);
        step(0, 0, 16'h0, 0);
        checks++; if (bus.pc_out !== 16'h0000 || bus.valid_out_IFID !== 1'b0 || bus.redirect !== 1'b0 ||
                      bus.pc_IFID !== 16'h0000 || bus.instr_IFID !== 16'h0000) begin
            errors++; $display("FAIL rst_flush got pc %h v%b r%b ifid %h/%h exp 0000 v0 r0 0000/0000",
                               bus.pc_out, bus.valid_out_IFID, bus.redirect, bus.pc_IFID, bus.instr_IFID); end
        step(0, 1, 16'h0040, 1);
        checks++; if (bus.pc_out !== 16'h0001 || bus.redirect !== 1'b0 || bus.valid_out_IFID !== 1'b0) begin
            errors++; $display("FAIL rst_flush_run1 got pc %h r%b v%b exp 0001 r0 v0", bus.pc_out, bus.redirect, bus.valid_out_IFID); end
        step(0, 0, 16'h0, 1);
        checks++; if (bus.pc_out !== 16'h0002 || bus.valid_out_IFID !== 1'b1 || bus.pc_IFID !== 16'h0000 || bus.instr_IFID !== 16'h1000) begin
            errors++; $display("FAIL rst_flush_run2 got pc %h v%b ifid %h/%h exp 0002 v1 0000/1000", bus.pc_out, bus.valid_out_IFID, bus.pc_IFID, bus.instr_IFID); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic s, bv, rn;
            s  = ($urandom_range(0, 3) == 0);
            bv = ($urandom_range(0, 5) == 0);
            rn = ($urandom_range(0, 49) != 0);
            step(s, bv, 16'($urandom), rn);
            checks++; if (bus.pc_out !== m_pc) begin errors++; $display("FAIL rand_pc_out cyc %0d got %h exp %h", i, bus.pc_out, m_pc); end
            checks++; if (bus.valid_out_IFID !== m_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, bus.valid_out_IFID, m_valid); end
            checks++; if (bus.redirect !== m_redirect) begin errors++; $display("FAIL rand_redirect cyc %0d got %b exp %b", i, bus.redirect, m_redirect); end
            if (m_valid) begin
                checks++; if (bus.pc_IFID !== m_pcifid || bus.instr_IFID !== memf(m_pcifid)) begin
                    errors++; $display("FAIL rand_ifid cyc %0d got %h/%h exp %h/%h", i, bus.pc_IFID, bus.instr_IFID, m_pcifid, memf(m_pcifid)); end
            end
        end
    endtask

    initial begin
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_target = 16'h0000;
        bus.instr_in  = 16'h0000;
        m_pc = 16'h0000; m_valid = 1'b0; m_pcifid = 16'h0000; m_redirect = 1'b0;
        m_flush = 1'b0; m_pending = 2; m_next = 16'h0000;
        test_reset();
        test_redirect();
        test_stall();
        test_stall_branch();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
